// File: rtl/hub75_scan_pkg.sv
// Shared definitions for the HUB75 row-scan sequencer: row-order codes
// and the scan FSM state encoding.
package hub75_scan_pkg;

    // Row-order selector values; any other code falls back to linear.
    localparam logic [1:0] ORD_LINEAR     = 2'd0;
    localparam logic [1:0] ORD_INTERLEAVE = 2'd1;
    localparam logic [1:0] ORD_REVERSE    = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PAINT = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/hub75_row_map.sv
// Combinational row-address mapper: turns the scan sequence index into the
// physical row address for the selected row order. Shared with the
// frame-buffer side so both agree on the physical row.
module hub75_row_map
    import hub75_scan_pkg::*;
#(
    parameter int LOG_N_ROWS = 5
) (
    input  logic [LOG_N_ROWS-1:0] seq,
    input  logic [1:0]            order,
    output logic [LOG_N_ROWS-1:0] addr
);

    logic [LOG_N_ROWS-1:0] half;

    // Row count is a power of two, so (N_ROWS-1) - x is simply ~x.
    always_comb begin
        half = seq >> 1;
        addr = seq;
        case (order)
            ORD_REVERSE:    addr = ~seq;
            ORD_INTERLEAVE: addr = seq[0] ? ~half : half;
            default:        addr = seq;
        endcase
    end

endmodule

// File: rtl/hub75_scan_seq.sv
// HUB75 row-scan sequencer: per row requests a back-buffer load, waits for
// the frame buffer and BCM engine to be ready, then fires paint + swap,
// optionally followed by a blanking gap. Supports run-time row order,
// continuous multi-frame scanning with a stop request, and frame counting.
module hub75_scan_seq
    import hub75_scan_pkg::*;
#(
    parameter int N_ROWS     = 32,
    parameter int GAP_W      = 8,
    parameter int FRAME_W    = 16,
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [LOG_N_ROWS-1:0] bcm_row,
    output logic                  bcm_go,
    input  logic                  bcm_rdy,
    output logic [LOG_N_ROWS-1:0] fb_row_addr,
    output logic                  fb_row_load,
    input  logic                  fb_row_rdy,
    output logic                  fb_row_swap,
    input  logic [1:0]            cfg_order,
    input  logic [GAP_W-1:0]      cfg_gap,
    input  logic                  cfg_cont,
    input  logic                  ctrl_go,
    input  logic                  ctrl_stop,
    output logic                  ctrl_rdy,
    output logic                  frame_done,
    output logic [FRAME_W-1:0]    frame_cnt
);

    localparam logic [LOG_N_ROWS-1:0] SEQ_LAST = LOG_N_ROWS'(N_ROWS - 1);

    state_t                state;
    state_t                state_nxt;
    logic [LOG_N_ROWS-1:0] seq;
    logic [LOG_N_ROWS-1:0] row_addr;
    logic [1:0]            ord_q;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  stop_pend;
    logic                  last_q;
    logic                  is_last;
    logic                  stop_eff;
    logic                  exit_idle;

    hub75_row_map #(
        .LOG_N_ROWS(LOG_N_ROWS)
    ) u_row_map (
        .seq   (seq),
        .order (ord_q),
        .addr  (row_addr)
    );

    // Row-boundary exit decision shared by PAINT and GAP. In GAP, seq has
    // already advanced, so the "last row" flag captured in PAINT is used.
    // A stop raised in the deciding cycle itself is honoured as well.
    always_comb begin
        is_last   = (state == ST_PAINT) ? (seq == SEQ_LAST) : last_q;
        stop_eff  = stop_pend | ctrl_stop;
        exit_idle = stop_eff | (is_last & ~cfg_cont);
    end

    // State register; asynchronous reset returns straight to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ctrl_go) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bcm_rdy && fb_row_rdy) begin
                    state_nxt = ST_PAINT;
                end
            end
            ST_PAINT: begin
                if (cfg_gap != '0) begin
                    state_nxt = ST_GAP;
                end else if (exit_idle) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = exit_idle ? ST_IDLE : ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state; all strobes are single-cycle
    // because LOAD and PAINT never last more than one cycle.
    always_comb begin
        ctrl_rdy    = 1'b0;
        fb_row_load = 1'b0;
        bcm_go      = 1'b0;
        fb_row_swap = 1'b0;
        frame_done  = 1'b0;
        case (state)
            ST_IDLE:  ctrl_rdy    = 1'b1;
            ST_LOAD:  fb_row_load = 1'b1;
            ST_PAINT: begin
                bcm_go      = 1'b1;
                fb_row_swap = 1'b1;
                frame_done  = (seq == SEQ_LAST);
            end
            default: ;
        endcase
        bcm_row     = row_addr;
        fb_row_addr = row_addr;
    end

    // Sequence index, order latch, gap counter, stop latch and frame count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq       <= '0;
            ord_q     <= ORD_LINEAR;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
            last_q    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    seq       <= '0;
                    ord_q     <= cfg_order;
                    // go and stop together: scan row 0, then stop.
                    stop_pend <= ctrl_go & ctrl_stop;
                end
                ST_PAINT: begin
                    seq       <= seq + LOG_N_ROWS'(1);
                    gap_cnt   <= cfg_gap;
                    last_q    <= (seq == SEQ_LAST);
                    stop_pend <= stop_pend | ctrl_stop;
                    if (seq == SEQ_LAST) begin
                        frame_cnt <= frame_cnt + FRAME_W'(1);
                        // Order changes only take effect at frame boundaries.
                        if (cfg_cont) begin
                            ord_q <= cfg_order;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt   <= gap_cnt - GAP_W'(1);
                    stop_pend <= stop_pend | ctrl_stop;
                end
                default: begin
                    stop_pend <= stop_pend | ctrl_stop;
                end
            endcase
        end
    end

endmodule
